frame_pixel_streamer: RTL and testbench

//   Source end of the pixel stream consumed by the effect filters (inversion etc.). Reads one frame
//   of RGB444 pixels from a frame-buffer RAM in raster order and emits them on a valid/ready stream

---
 rtl/frame_pixel_streamer.sv | 125 ++++++++++++
 tb/tb_frame_pixel_streamer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_pixel_streamer.sv
// Raster-order frame-buffer reader feeding a valid/ready RGB444 pixel stream.
// A 2-entry output FIFO absorbs the one-cycle RAM latency; reads are gated so it can never overflow.
module frame_pixel_streamer #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int DATA_W = 12,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        freq_flag_in,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic [2:0]        freq_flag
);

  localparam int XW = $clog2(WIDTH);
  localparam logic [XW-1:0]     X_LAST = XW'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(WIDTH * HEIGHT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [XW-1:0]     x;
  logic              in_flight;
  logic              fl_sof;
  logic              fl_eol;
  logic [DATA_W+1:0] fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              issue;
  logic              push;
  logic              pop;

  // Gate uses only registered occupancy, so m_ready never reaches mem_rd_en.
  assign issue     = (state == S_FETCH) && ((count + {1'b0, in_flight}) < 2'd2);
  assign mem_rd_en = issue;
  assign mem_addr  = addr;
  assign push      = in_flight;
  assign m_valid   = (count != 2'd0);
  assign pop       = m_valid && m_ready;
  assign {m_data, m_sof, m_eol} = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      freq_flag <= 3'd0;
      addr      <= '0;
      x         <= '0;
      fl_sof    <= 1'b0;
      fl_eol    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FETCH;
            busy      <= 1'b1;
            freq_flag <= freq_flag_in;
            addr      <= '0;
            x         <= '0;
          end
        end
        S_FETCH: begin
          if (issue) begin
            // Tags are fixed at issue time and ride alongside the returning data.
            fl_sof <= (addr == '0);
            fl_eol <= (x == X_LAST);
            x      <= (x == X_LAST) ? '0 : x + 1'b1;
            if (addr == A_LAST) state <= S_DRAIN;
            else addr <= addr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (pop && (count == 2'd1) && !in_flight) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            addr  <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_flight   <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      in_flight <= issue;
      if (push) begin
        fifo_mem[wr_ptr] <= {mem_rdata, fl_sof, fl_eol};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Bench for frame_pixel_streamer on a 4x2 frame with RAM preloaded mem[i] = 12'h100 + i.
// Expected stream is derived from raster rules; a monitor loop gathers observations per scenario.
module tb_frame_pixel_streamer;
  localparam int W = 4;
  localparam int H = 2;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  freq_flag_in;
  logic        busy, done, mem_rd_en;
  logic [3:0]  mem_addr;
  logic [11:0] mem_rdata;
  logic        m_valid, m_ready;
  logic [11:0] m_data;
  logic        m_sof, m_eol;
  logic [2:0]  freq_flag;

  logic [11:0] mem [N];

  int checks = 0;
  int failures = 0;

  logic [13:0] obs_q[$];
  int rd_total, rd_early, occ_viol, addr_viol, stab_viol, ff_viol;
  int done_count, done_gap, done_busy_bad, first_rd, first_valid;

  frame_pixel_streamer #(.WIDTH(W), .HEIGHT(H), .DATA_W(12), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .freq_flag_in(freq_flag_in),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .freq_flag(freq_flag)
  );

  always #5 clk = ~clk;

  // One-cycle-latency RAM; garbage on idle cycles exposes any use of unrequested data.
  always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr[2:0]] : 12'($urandom);

  function automatic logic [13:0] exp_pix(input int i);
    return {12'h100 + 12'(i), (i == 0), ((i % W) == W - 1)};
  endfunction

  task automatic pulse_start(input logic [2:0] ff);
    start = 1'b1;
    freq_flag_in = ff;
    @(posedge clk); #1;
    start = 1'b0;
    freq_flag_in = 3'($urandom);
  endtask

  // mode: 0 ready high, 1 ready 1,0,0 pattern, 2 ready low for 10 cycles, 3 random
  task automatic collect(input int mode, input logic [2:0] exp_ff, input int stop_hs, input bit inject);
    int hs = 0;
    int last_hs = -100;
    bit prev_stall = 1'b0;
    logic [13:0] prev = '0;
    obs_q.delete();
    rd_total = 0; rd_early = 0; occ_viol = 0; addr_viol = 0; stab_viol = 0; ff_viol = 0;
    done_count = 0; done_gap = -1; done_busy_bad = 0; first_rd = -1; first_valid = -1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = (cyc % 3 == 0);
        2: m_ready = (cyc >= 10);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (inject && cyc == 4) begin start = 1'b1; freq_flag_in = 3'd5; end
      else start = 1'b0;
      @(negedge clk);
      if (mem_rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        if (int'(mem_addr) != rd_total) addr_viol++;
        if (rd_total - hs >= 2) occ_viol++;
        if (cyc < 10) rd_early++;
        rd_total++;
      end
      if (m_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (prev_stall && {m_data, m_sof, m_eol} !== prev) stab_viol++;
      end
      if (busy && freq_flag !== exp_ff) ff_viol++;
      if (done) begin
        done_count++;
        if (busy) done_busy_bad++;
        done_gap = cyc - last_hs;
      end
      prev_stall = m_valid && !m_ready;
      prev = {m_data, m_sof, m_eol};
      if (m_valid && m_ready) begin
        obs_q.push_back({m_data, m_sof, m_eol});
        hs++;
        last_hs = cyc;
      end
      @(posedge clk); #1;
      if (stop_hs > 0 && hs == stop_hs) break;
      if (done_count > 0 && cyc >= last_hs + 3) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    int bad = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({busy, done, mem_rd_en, mem_addr, m_valid, m_data, m_sof, m_eol, freq_flag} !== '0) begin
      failures++;
      $display("FAIL reset_values: got busy=%b done=%b rd=%b addr=%0d valid=%b data=%h sof=%b eol=%b ff=%0d, want all 0",
               busy, done, mem_rd_en, mem_addr, m_valid, m_data, m_sof, m_eol, freq_flag);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_valid || mem_rd_en || busy) bad++;
    end
    @(posedge clk); #1;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL idle_quiet: got %0d active cycles, want 0", bad);
    end
  endtask

  task automatic test_stream_full_rate;
    pulse_start(3'd2);
    collect(0, 3'd2, 0, 1'b0);
    checks++;
    if (obs_q.size() != N) begin
      failures++;
      $display("FAIL full_rate_count: got %0d pixels, want %0d", obs_q.size(), N);
    end
    for (int i = 0; i < N && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_pix(i)) begin
        failures++;
        $display("FAIL full_rate_pix%0d: got %h, want %h", i, obs_q[i], exp_pix(i));
      end
    end
    checks++;
    if (first_rd != 0 || first_valid != 2) begin
      failures++;
      $display("FAIL latency: got first_rd=%0d first_valid=%0d, want 0 and 2", first_rd, first_valid);
    end
    checks++;
    if (done_count != 1 || done_gap != 1 || done_busy_bad != 0) begin
      failures++;
      $display("FAIL done_pulse: got count=%0d gap=%0d busy_with_done=%0d, want 1 1 0",
               done_count, done_gap, done_busy_bad);
    end
    checks++;
    if (ff_viol != 0 || freq_flag !== 3'd2) begin
      failures++;
      $display("FAIL freq_latch: got %0d bad cycles ff=%0d, want 0 and 2", ff_viol, freq_flag);
    end
  endtask

  task automatic test_ready_toggle;
    pulse_start(3'd3);
    collect(1, 3'd3, 0, 1'b0);
    checks++;
    if (obs_q.size() != N) begin
      failures++;
      $display("FAIL toggle_count: got %0d pixels, want %0d", obs_q.size(), N);
    end
    for (int i = 0; i < N && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_pix(i)) begin
        failures++;
        $display("FAIL toggle_pix%0d: got %h, want %h", i, obs_q[i], exp_pix(i));
      end
    end
    checks++;
    if (stab_viol != 0 || occ_viol != 0 || addr_viol != 0) begin
      failures++;
      $display("FAIL toggle_flow: got stab=%0d occ=%0d addr=%0d violations, want 0 0 0",
               stab_viol, occ_viol, addr_viol);
    end
  endtask

  task automatic test_stall_start;
    pulse_start(3'd1);
    collect(2, 3'd1, 0, 1'b0);
    checks++;
    if (rd_early != 2 || addr_viol != 0) begin
      failures++;
      $display("FAIL stall_reads: got %0d reads in stall addr_viol=%0d, want 2 and 0", rd_early, addr_viol);
    end
    checks++;
    if (obs_q.size() != N) begin
      failures++;
      $display("FAIL stall_count: got %0d pixels, want %0d", obs_q.size(), N);
    end
    for (int i = 0; i < N && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_pix(i)) begin
        failures++;
        $display("FAIL stall_pix%0d: got %h, want %h", i, obs_q[i], exp_pix(i));
      end
    end
  endtask

  task automatic test_restart_ignored;
    pulse_start(3'd2);
    collect(3, 3'd2, 0, 1'b1);
    checks++;
    if (ff_viol != 0 || freq_flag !== 3'd2 || done_count != 1) begin
      failures++;
      $display("FAIL restart_ignored: got ff_bad=%0d ff=%0d done=%0d, want 0 2 1", ff_viol, freq_flag, done_count);
    end
    checks++;
    if (obs_q.size() != N || rd_total != N || occ_viol != 0 || stab_viol != 0) begin
      failures++;
      $display("FAIL restart_frame: got pix=%0d reads=%0d occ=%0d stab=%0d, want %0d %0d 0 0",
               obs_q.size(), rd_total, occ_viol, stab_viol, N, N);
    end
    for (int i = 0; i < N && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_pix(i)) begin
        failures++;
        $display("FAIL restart_pix%0d: got %h, want %h", i, obs_q[i], exp_pix(i));
      end
    end
  endtask

  task automatic test_mid_reset;
    pulse_start(3'd2);
    collect(0, 3'd2, 3, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, mem_rd_en, mem_addr, m_valid, m_data, m_sof, m_eol, freq_flag} !== '0) begin
      failures++;
      $display("FAIL mid_reset_values: got busy=%b done=%b rd=%b addr=%0d valid=%b data=%h sof=%b eol=%b ff=%0d, want all 0",
               busy, done, mem_rd_en, mem_addr, m_valid, m_data, m_sof, m_eol, freq_flag);
    end
    @(posedge clk); #1;
    pulse_start(3'd6);
    collect(0, 3'd6, 0, 1'b0);
    checks++;
    if (obs_q.size() != N || obs_q[0] !== exp_pix(0)) begin
      failures++;
      $display("FAIL mid_reset_restart: got %0d pixels first=%h, want %0d first=%h",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 14'h0, N, exp_pix(0));
    end
  endtask

  task automatic test_back_to_back;
    for (int f = 0; f < 3; f++) begin
      logic [2:0] ff;
      int bad;
      ff = 3'($urandom);
      pulse_start(ff);
      collect(3, ff, 0, 1'b0);
      bad = 0;
      for (int i = 0; i < N && i < obs_q.size(); i++)
        if (obs_q[i] !== exp_pix(i)) bad++;
      checks++;
      if (obs_q.size() != N || bad != 0 || ff_viol != 0 || occ_viol != 0 || done_count != 1) begin
        failures++;
        $display("FAIL b2b_frame%0d: got pix=%0d bad=%0d ff_bad=%0d occ=%0d done=%0d, want %0d 0 0 0 1",
                 f, obs_q.size(), bad, ff_viol, occ_viol, done_count, N);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = 12'h100 + 12'(i);
    reset = 1'b1;
    start = 1'b0;
    freq_flag_in = 3'd0;
    m_ready = 1'b0;
    test_reset();
    test_stream_full_rate();
    test_ready_toggle();
    test_stall_start();
    test_restart_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
